decrypter: RTL and testbench
============================

DECRYPTER -- requirements
Module: decrypter

Interface
REQ-001 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-002 Rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  data_to_be_decrypt valid.
REQ-004 in_ready  output  1  block can accept a word.
REQ-005 data_to_be_decrypt  input  78  encrypted word, fields {rand6[77:72], rand11[71:61], parity[60], cipher[59:0]}.
REQ-006 out_valid  output  1  result valid.
REQ-007 out_ready  input  1  downstream accepts result.
REQ-008 output_decrypted  output  60  recovered plaintext.
REQ-009 out_err  output  1  parity failure on this word.
REQ-010 out_mode  output  2  decrypt function used (= rand6[1:0]).
REQ-011 err_count  output  8  saturating count of parity failures.

Function
REQ-012 The block SHALL derive the keystream K60 = {rand11[4:0], rand11, rand11, rand11, rand11, rand11}, i.e. 5 + 5x11 = 60 bits.
REQ-013 The block SHALL derive rotation amount r = rand6 when rand6 < 60, else rand6 - 60.
REQ-014 The block SHALL decrypt according to mode = rand6[1:0]:
- mode 0: cipher ^ K60.
- mode 1: rotr60(cipher, r) ^ K60.
- mode 2: (cipher - K60) mod 2^60.
- mode 3: bitreverse(cipher ^ ~K60).
REQ-015 The parity check SHALL pass when the parity bit equals the XOR of cipher[59:0].
REQ-016 The FSM SHALL have states IDLE, CAPTURE, CHECK, XFORM and HOLD, with transitions:
- IDLE -> CAPTURE on handshake.
- CAPTURE -> CHECK -> XFORM -> HOLD unconditionally.
- HOLD -> IDLE on out_valid & out_ready.
REQ-017 in_ready SHALL be 1 only in IDLE, and the input word SHALL be registered on in_valid & in_ready.
REQ-018 Latency: handshake at cycle N SHALL give out_valid = 1 at cycle N+4, with outputs registered in HOLD.
REQ-019 In HOLD, output_decrypted, out_err and out_mode SHALL stay stable until out_ready = 1, with no new input accepted.
REQ-020 On parity failure the block SHALL drive out_err = 1 and output_decrypted = 0, and SHALL increment err_count by 1 at the HOLD->IDLE transition, saturating at 8'hFF.
REQ-021 Simultaneous in_valid and out_ready in HOLD SHALL complete the output only; the next input is accepted no earlier than the following IDLE cycle.
REQ-022 in_valid asserted while not in IDLE SHALL be ignored, with no state change.

Reset
REQ-023 Rst = 1 SHALL force, at the next posedge:
- state = IDLE, in_ready = 1;
- out_valid = 0, out_err = 0;
- output_decrypted = 0, out_mode = 0, err_count = 0.
REQ-024 Rst mid-operation (any state) SHALL abort the word with no output produced and err_count cleared; Rst SHALL take priority over all handshakes.

Configuration
REQ-025 With macro DECRYPTER_PARITY_CHECK_EN defined, parity SHALL be checked per REQ-015 and REQ-020.
REQ-026 Without DECRYPTER_PARITY_CHECK_EN:
- parity bit ignored;
- out_err tied 0, err_count tied 0;
- CHECK state still traversed, so latency is unchanged.

Structure
REQ-027 Shared package crypt_pkg SHALL hold:
- width constants: DATA_W = 60, ENC_W = 78, R6_W = 6, R11_W = 11;
- field bit positions;
- the 2-bit mode enum, shared with the encrypt side;
- the K60 derivation function.
REQ-028 One combinational sub-module decrypt_core SHALL take (cipher, rand6, rand11) and produce plaintext; decrypter owns the FSM, handshakes and counters.

Verification
REQ-029 Mode 0: input {6'd0, 11'd0, 1'b0, 60'h123} -> at N+4, output_decrypted = 60'h123, out_err = 0, out_mode = 0.
REQ-030 Mode 1: input {6'd5, 11'd0, 1'b1, 60'h1} -> output_decrypted = 60'h080000000000000 (bit 55), out_mode = 1.
REQ-031 Mode 2 and mode 3:
- rand6 = 2, rand11 = 1, cipher = K60, parity 0 -> output 0.
- rand6 = 3, rand11 = 0, cipher 0, parity 0 -> output 60'hFFFFFFFFFFFFFFF.
REQ-032 Parity error: mode 0, cipher 60'h123, parity 1 -> out_err = 1, output 0, err_count = 1. 300 such words -> err_count = 8'hFF.
REQ-033 Backpressure: out_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready = 0, in_valid ignored. out_ready = 1 -> IDLE next cycle.
REQ-034 Reset mid-operation: Rst pulsed in XFORM -> next cycle IDLE, out_valid never asserted, all outputs 0.

Source files
------------

// File: rtl/crypt_pkg.sv
// crypt_pkg: widths, word field positions, decrypt mode enum and keystream shared by the crypt blocks
package crypt_pkg;
  localparam int DATA_W = 60;
  localparam int ENC_W = 78;
  localparam int R6_W = 6;
  localparam int R11_W = 11;
  localparam int CIPHER_LSB = 0;
  localparam int CIPHER_MSB = 59;
  localparam int PARITY_BIT = 60;
  localparam int R11_LSB = 61;
  localparam int R11_MSB = 71;
  localparam int R6_LSB = 72;
  localparam int R6_MSB = 77;
  typedef enum logic [1:0] {MODE_XOR, MODE_ROT, MODE_SUB, MODE_REV} mode_e;
  function automatic logic [DATA_W-1:0] k60(input logic [R11_W-1:0] r11);
    return {r11[4:0], {5{r11}}};
  endfunction
endpackage

// File: rtl/decrypter_if.sv
// decrypter_if: input word and result handshakes of the decrypter
interface decrypter_if;
  import crypt_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [ENC_W-1:0] data_to_be_decrypt;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] output_decrypted;
  logic out_err;
  logic [1:0] out_mode;
  logic [7:0] err_count;
  modport master (
    output in_valid, data_to_be_decrypt, out_ready,
    input in_ready, out_valid, output_decrypted, out_err, out_mode, err_count
  );
  modport slave (
    input in_valid, data_to_be_decrypt, out_ready,
    output in_ready, out_valid, output_decrypted, out_err, out_mode, err_count
  );
endinterface

// File: rtl/decrypt_core.sv
// decrypt_core: combinational plaintext recovery for the four keystream modes
module decrypt_core
  import crypt_pkg::*;
(
  input  logic [DATA_W-1:0] cipher,
  input  logic [R6_W-1:0]   rand6,
  input  logic [R11_W-1:0]  rand11,
  output logic [DATA_W-1:0] plain
);
  logic [DATA_W-1:0] k, rot, inv, rev;
  logic [R6_W-1:0] r;
  mode_e mode;
  always_comb begin
    k = k60(rand11);
    mode = mode_e'(rand6[1:0]);
    r = rand6 < R6_W'(DATA_W) ? rand6 : rand6 - R6_W'(DATA_W);
    rot = DATA_W'({cipher, cipher} >> r);
    inv = cipher ^ ~k;
    rev = '0;
    for (int i = 0; i < DATA_W; i++) rev[i] = inv[DATA_W-1-i];
    plain = mode == MODE_XOR ? cipher ^ k :
            mode == MODE_ROT ? rot ^ k :
            mode == MODE_SUB ? cipher - k : rev;
  end
endmodule

// File: rtl/decrypter.sv
// decrypter: handshaked 4-cycle decrypt FSM with parity error count (enabled by DECRYPTER_PARITY_CHECK_EN)
module decrypter
  import crypt_pkg::*;
(
  input logic Clk,
  input logic Rst,
  decrypter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, XFORM, HOLD} state_e;
  state_e state_q, state_d;
  logic [DATA_W-1:0] cipher_q, cipher_d;
  logic [R6_W-1:0] rand6_q, rand6_d;
  logic [R11_W-1:0] rand11_q, rand11_d;
  logic par_err_q, par_err_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic out_err_q, out_err_d;
  logic [1:0] out_mode_q, out_mode_d;
  logic [7:0] err_count_q, err_count_d;
  logic [DATA_W-1:0] plain;
  logic accept, done, load;
`ifdef DECRYPTER_PARITY_CHECK_EN
  logic parity_q, parity_d;
`endif
  decrypt_core u_core (
    .cipher(cipher_q),
    .rand6(rand6_q),
    .rand11(rand11_q),
    .plain(plain)
  );
  always_comb begin
    accept = state_q == IDLE && bus.in_valid;
    done = state_q == HOLD && bus.out_ready;
    load = state_q == XFORM;
    state_d = state_q == IDLE ? (accept ? CAPTURE : IDLE) :
              state_q == CAPTURE ? CHECK :
              state_q == CHECK ? XFORM :
              state_q == XFORM ? HOLD : (done ? IDLE : HOLD);
    cipher_d = accept ? bus.data_to_be_decrypt[CIPHER_MSB:CIPHER_LSB] : cipher_q;
    rand6_d = accept ? bus.data_to_be_decrypt[R6_MSB:R6_LSB] : rand6_q;
    rand11_d = accept ? bus.data_to_be_decrypt[R11_MSB:R11_LSB] : rand11_q;
`ifdef DECRYPTER_PARITY_CHECK_EN
    parity_d = accept ? bus.data_to_be_decrypt[PARITY_BIT] : parity_q;
    par_err_d = state_q == CHECK ? parity_q != ^cipher_q : par_err_q;
    err_count_d = done && out_err_q && err_count_q != 8'hFF ? err_count_q + 8'd1 : err_count_q;
`else
    par_err_d = 1'b0;
    err_count_d = '0;
`endif
    // a failed word is reported with an all-zero plaintext
    out_data_d = load ? (par_err_q ? '0 : plain) : out_data_q;
    out_err_d = load ? par_err_q : out_err_q;
    out_mode_d = load ? rand6_q[1:0] : out_mode_q;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cipher_q <= '0;
      rand6_q <= '0;
      rand11_q <= '0;
      par_err_q <= 1'b0;
      out_data_q <= '0;
      out_err_q <= 1'b0;
      out_mode_q <= '0;
      err_count_q <= '0;
`ifdef DECRYPTER_PARITY_CHECK_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cipher_q <= cipher_d;
      rand6_q <= rand6_d;
      rand11_q <= rand11_d;
      par_err_q <= par_err_d;
      out_data_q <= out_data_d;
      out_err_q <= out_err_d;
      out_mode_q <= out_mode_d;
      err_count_q <= err_count_d;
`ifdef DECRYPTER_PARITY_CHECK_EN
      parity_q <= parity_d;
`endif
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == HOLD;
  assign bus.output_decrypted = out_data_q;
  assign bus.out_err = out_err_q;
  assign bus.out_mode = out_mode_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_decrypter.sv
// tb_decrypter: randomized and directed checks of decrypter against a bit-level reference model
module tb_decrypter;
`ifdef DECRYPTER_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Rst;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  decrypter_if bus();
  decrypter dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;

  // keystream bit j repeats rand11 with period 11; rotation uses rand6 mod 60
  function automatic logic [59:0] ref_plain(input logic [77:0] w);
    logic [5:0] r6;
    logic [10:0] r11;
    logic [59:0] c, k, t, o;
    int r;
    r6 = w[77:72];
    r11 = w[71:61];
    c = w[59:0];
    for (int j = 0; j < 60; j++) k[j] = r11[j % 11];
    r = int'(r6) % 60;
    t = '0;
    o = '0;
    case (r6[1:0])
      2'd0: o = c ^ k;
      2'd1: begin
        for (int j = 0; j < 60; j++) t[j] = c[(j + r) % 60];
        o = t ^ k;
      end
      2'd2: o = c - k;
      default: begin
        t = c ^ ~k;
        for (int j = 0; j < 60; j++) o[j] = t[59 - j];
      end
    endcase
    return o;
  endfunction

  function automatic logic ref_par(input logic [59:0] c);
    int ones = 0;
    for (int j = 0; j < 60; j++) ones += int'(c[j]);
    return ones[0];
  endfunction

  function automatic logic [77:0] rnd_word();
    return {6'($urandom), 11'($urandom), 1'($urandom), 28'($urandom), 32'($urandom)};
  endfunction

  task automatic do_word(input logic [77:0] w, input int stall, input bit use_k, input logic [59:0] kd);
    logic [59:0] ed;
    logic ee;
    logic [1:0] em;
    int n;
    ee = PAR_EN && (w[60] != ref_par(w[59:0]));
    ed = ee ? 60'd0 : (use_k ? kd : ref_plain(w));
    em = w[73:72];
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 10) begin
      @(posedge Clk); #1;
      n++;
    end
    bus.data_to_be_decrypt = w;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 8) begin
      @(posedge Clk); #1;
      n++;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL latency: got %0d edges after handshake, expected 3", n); end
    checks++;
    if (bus.output_decrypted !== ed) begin errors++; $display("FAIL data w=%h: got %h expected %h", w, bus.output_decrypted, ed); end
    checks++;
    if (bus.out_err !== ee) begin errors++; $display("FAIL out_err w=%h: got %b expected %b", w, bus.out_err, ee); end
    checks++;
    if (bus.out_mode !== em) begin errors++; $display("FAIL out_mode w=%h: got %0d expected %0d", w, bus.out_mode, em); end
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'($urandom);
      bus.data_to_be_decrypt = rnd_word();
      @(posedge Clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.output_decrypted !== ed || bus.out_err !== ee || bus.out_mode !== em) begin
        errors++;
        $display("FAIL hold cycle %0d: valid=%b ready=%b data=%h err=%b mode=%0d expected 1 0 %h %b %0d", s, bus.out_valid, bus.in_ready, bus.output_decrypted, bus.out_err, bus.out_mode, ed, ee, em);
      end
    end
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    if (ee && exp_cnt < 255) exp_cnt++;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL err_count: got %0d expected %0d", bus.err_count, exp_cnt); end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    bus.data_to_be_decrypt = rnd_word();
    repeat (2) @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    Rst = 1'b0;
    exp_cnt = 0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset out_err: got %b expected 0", bus.out_err); end
    checks++;
    if (bus.output_decrypted !== 60'd0) begin errors++; $display("FAIL reset data: got %h expected 0", bus.output_decrypted); end
    checks++;
    if (bus.out_mode !== 2'd0) begin errors++; $display("FAIL reset out_mode: got %0d expected 0", bus.out_mode); end
    checks++;
    if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset err_count: got %0d expected 0", bus.err_count); end
  endtask

  task automatic test_known();
    do_word({6'd0, 11'd0, 1'b0, 60'h123}, 0, 1'b1, 60'h123);
    do_word({6'd5, 11'd0, 1'b1, 60'h1}, 0, 1'b1, 60'h080000000000000);
    do_word({6'd2, 11'd1, 1'b0, 60'h080100200400801}, 0, 1'b1, 60'h0);
    do_word({6'd3, 11'd0, 1'b0, 60'h0}, 0, 1'b1, 60'hFFFFFFFFFFFFFFF);
    do_word({6'd0, 11'd0, 1'b1, 60'h123}, 0, 1'b1, 60'h123);
    do_word({6'd63, 11'h5A5, 1'b0, 60'h0}, 1, 1'b0, 60'h0);
    do_word({6'd61, 11'h7FF, 1'b1, 60'hFFFFFFFFFFFFFFF}, 1, 1'b0, 60'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) do_word(rnd_word(), int'($urandom_range(0, 3)), 1'b0, 60'h0);
  endtask

  task automatic test_backpressure();
    do_word(rnd_word(), 5, 1'b0, 60'h0);
    do_word({6'd0, 11'd0, 1'b1, 60'h123}, 5, 1'b0, 60'h0);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_word({6'd1, 11'h3F1, 1'b0, 60'hABCDEF}, 0, 1'b0, 60'h0);
    do_word({6'd0, 11'd0, 1'b1, 60'h123}, 0, 1'b0, 60'h0);
    bus.data_to_be_decrypt = rnd_word();
    bus.in_valid = 1'b1;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    bus.out_ready = 1'b0;
    exp_cnt = 0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_err !== 1'b0 || bus.output_decrypted !== 60'd0 || bus.out_mode !== 2'd0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL mid reset: ready=%b valid=%b err=%b data=%h mode=%0d cnt=%0d expected 1 0 0 0 0 0", bus.in_ready, bus.out_valid, bus.out_err, bus.output_decrypted, bus.out_mode, bus.err_count);
    end
    repeat (6) begin
      @(posedge Clk); #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid reset out_valid: asserted %0d cycles expected 0", seen); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) do_word({6'd0, 11'd0, 1'b1, 60'h123}, 0, 1'b0, 60'h0);
    checks++;
    if (bus.err_count !== (PAR_EN ? 8'hFF : 8'h00)) begin
      errors++;
      $display("FAIL saturation: got %0d expected %0d", bus.err_count, PAR_EN ? 255 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_to_be_decrypt = '0;
    Rst = 1'b1;
    test_reset();
    test_known();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
